// File: rtl/mesh_link.sv
// mesh_link: elastic valid/ready stage between adjacent mesh router nodes.
// PASS buffers flits in a DEPTH-entry FIFO, SINK swallows and counts them, BLOCK refuses all.
module mesh_link #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned MODE       = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       vin,
    output logic                       rout,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       vout,
    input  logic                       rin,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_WIDTH-1:0]       flit_count,
    output logic [CNT_WIDTH-1:0]       drop_count
);
    localparam int unsigned OccW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit IsPass = (MODE == 0);
    localparam bit IsSink = (MODE == 1);
    localparam logic [PtrW-1:0]      PtrLast = PtrW'(DEPTH - 1);
    localparam logic [OccW-1:0]      OccFull = OccW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CntMax  = '1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [OccW-1:0]       occ_q, occ_d;
    logic [CNT_WIDTH-1:0]  flit_cnt_q, flit_cnt_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic                  push, pop;

    // Non-power-of-two depths need an explicit wrap rather than natural overflow.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == CntMax) ? c : c + 1'b1;
    endfunction

    // Handshake outputs depend on registered state only, so rin never reaches rout.
    always_comb begin
        rout = 1'b0;
        vout = 1'b0;
        dout = '0;
        if (IsPass) begin
            rout = (occ_q < OccFull);
            vout = (occ_q != '0);
            dout = vout ? mem_q[rd_ptr_q] : '0;
        end else if (IsSink) begin
            rout = 1'b1;
        end
    end

    assign push = vin && rout;
    assign pop  = vout && rin;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        flit_cnt_d = flit_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (IsPass) begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d   = ptr_inc(rd_ptr_q);
                flit_cnt_d = sat_inc(flit_cnt_q);
            end
            if (push && !pop) begin
                occ_d = occ_q + 1'b1;
            end else if (pop && !push) begin
                occ_d = occ_q - 1'b1;
            end
        end else if (IsSink && push) begin
            flit_cnt_d = sat_inc(flit_cnt_q);
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            flit_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            flit_cnt_q <= flit_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; dout is masked while empty.
    always_ff @(posedge clk) begin
        if (IsPass && push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign occupancy  = occ_q;
    assign flit_count = flit_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_mesh_link.sv
// Bench for mesh_link: scoreboarded random traffic on a DEPTH=3 PASS link, plus
// directed DEPTH=2 full/pop, SINK saturation and BLOCK behaviour.
module tb_mesh_link;
    localparam int unsigned PD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Main scoreboarded PASS link, DEPTH=3.
    logic        p_rst = 1'b1, p_vin = 1'b0, p_rin = 1'b0;
    logic [31:0] p_din = '0;
    logic        p_rout, p_vout;
    logic [31:0] p_dout;
    logic [1:0]  p_occ;
    logic [15:0] p_fc, p_dc;

    mesh_link #(.DATA_WIDTH(32), .DEPTH(PD), .MODE(0), .CNT_WIDTH(16)) u_pass (
        .clk(clk), .rst(p_rst), .din(p_din), .vin(p_vin), .rout(p_rout), .dout(p_dout),
        .vout(p_vout), .rin(p_rin), .occupancy(p_occ), .flit_count(p_fc), .drop_count(p_dc)
    );

    // Default-parameter link (DEPTH=2), SINK and BLOCK links share one reset.
    logic        rst = 1'b1;
    logic        q_vin = 1'b0, q_rin = 1'b0;
    logic [31:0] q_din = '0;
    logic        q_rout, q_vout;
    logic [31:0] q_dout;
    logic [1:0]  q_occ;
    logic [15:0] q_fc, q_dc;

    mesh_link u_d2 (
        .clk(clk), .rst(rst), .din(q_din), .vin(q_vin), .rout(q_rout), .dout(q_dout),
        .vout(q_vout), .rin(q_rin), .occupancy(q_occ), .flit_count(q_fc), .drop_count(q_dc)
    );

    logic        s_vin = 1'b0;
    logic [31:0] s_din = '0;
    logic        s_rout, s_vout;
    logic [31:0] s_dout;
    logic [1:0]  s_occ;
    logic [3:0]  s_fc, s_dc;

    mesh_link #(.DATA_WIDTH(32), .DEPTH(2), .MODE(1), .CNT_WIDTH(4)) u_sink (
        .clk(clk), .rst(rst), .din(s_din), .vin(s_vin), .rout(s_rout), .dout(s_dout),
        .vout(s_vout), .rin(1'b1), .occupancy(s_occ), .flit_count(s_fc), .drop_count(s_dc)
    );

    logic        b_vin = 1'b0;
    logic [31:0] b_din = '0;
    logic        b_rout, b_vout;
    logic [31:0] b_dout;
    logic [1:0]  b_occ;
    logic [15:0] b_fc, b_dc;

    mesh_link #(.DATA_WIDTH(32), .DEPTH(2), .MODE(2), .CNT_WIDTH(16)) u_block (
        .clk(clk), .rst(rst), .din(b_din), .vin(b_vin), .rout(b_rout), .dout(b_dout),
        .vout(b_vout), .rin(1'b1), .occupancy(b_occ), .flit_count(b_fc), .drop_count(b_dc)
    );

    // Reference model: an ideal FIFO of accepted flits and a count of deliveries.
    logic [31:0] exp_q[$];
    int unsigned pops = 0;
    bit          mon_en = 1'b0;
    bit          p_acc = 1'b0;
    logic [31:0] p_acc_data = '0;

    always @(negedge clk) begin
        p_acc      = p_vin && p_rout && !p_rst;
        p_acc_data = p_din;
    end

    // Stimulus side: an accepted flit becomes an expected delivery.
    always @(posedge clk) begin
        if (p_rst) exp_q.delete();
        else if (p_acc) exp_q.push_back(p_acc_data);
    end

    // Monitor: compares the link against the model every cycle, pops on delivery.
    always @(negedge clk) begin
        if (p_rst) begin
            pops = 0;
        end else if (mon_en) begin
            check("p_occ", 64'(p_occ), 64'(exp_q.size()));
            check("p_vout", 64'(p_vout), 64'(exp_q.size() != 0));
            check("p_rout", 64'(p_rout), 64'(exp_q.size() < PD));
            check("p_fc", 64'(p_fc), (pops > 65535) ? 64'd65535 : 64'(pops));
            check("p_dc", 64'(p_dc), 64'd0);
            if (p_vout && p_rin && exp_q.size() != 0) begin
                check("p_dout", 64'(p_dout), 64'(exp_q.pop_front()));
                pops++;
            end else if (!p_vout) begin
                check("p_dout_idle", 64'(p_dout), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold rin low, offer a run of flits, confirm exactly PD land, then drain.
    task automatic fill_drain(input logic [31:0] base);
        p_rin = 1'b0;
        p_vin = 1'b1;
        p_din = base;
        for (int i = 0; i < PD + 2; i++) begin
            tick();
            if (p_acc) p_din = p_din + 1;
        end
        check("bp_occ", 64'(p_occ), 64'(PD));
        check("bp_rout", 64'(p_rout), 64'd0);
        check("bp_accepted", 64'(p_din), 64'(base + PD));
        p_vin = 1'b0;
        p_rin = 1'b1;
        for (int i = 0; i < PD + 1; i++) tick();
        check("drain_occ", 64'(p_occ), 64'd0);
    endtask

    initial begin
        // Reset everything.
        tick();
        tick();
        rst   = 1'b0;
        p_rst = 1'b0;
        mon_en = 1'b1;

        // Default link reset state.
        check("d2_rst_rout", 64'(q_rout), 64'd1);
        check("d2_rst_vout", 64'(q_vout), 64'd0);
        check("d2_rst_occ", 64'(q_occ), 64'd0);
        check("d2_rst_fc", 64'(q_fc), 64'd0);
        check("d2_rst_dout", 64'(q_dout), 64'd0);

        // DEPTH=2 full: a pop with vin high must not admit a push in the same cycle.
        q_vin = 1'b1;
        q_din = 32'h1;
        tick();
        q_din = 32'h2;
        tick();
        check("d2_full_occ", 64'(q_occ), 64'd2);
        check("d2_full_rout", 64'(q_rout), 64'd0);
        q_rin = 1'b1;
        q_din = 32'h3;
        check("d2_full_dout", 64'(q_dout), 64'h1);
        tick();
        check("d2_pop_occ", 64'(q_occ), 64'd1);
        check("d2_pop_dout", 64'(q_dout), 64'h2);
        check("d2_pop_rout", 64'(q_rout), 64'd1);
        tick();
        check("d2_both_occ", 64'(q_occ), 64'd1);
        check("d2_both_dout", 64'(q_dout), 64'h3);
        q_vin = 1'b0;
        tick();
        check("d2_end_occ", 64'(q_occ), 64'd0);
        check("d2_end_vout", 64'(q_vout), 64'd0);
        check("d2_end_fc", 64'(q_fc), 64'd3);

        // SINK with 4-bit saturating counters; BLOCK offered traffic at the same time.
        s_vin = 1'b1;
        b_vin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_din = $urandom;
            b_din = $urandom;
            tick();
            check("sink_rout", 64'(s_rout), 64'd1);
            check("sink_vout", 64'(s_vout), 64'd0);
            check("blk_rout", 64'(b_rout), 64'd0);
            check("blk_vout", 64'(b_vout), 64'd0);
            if (i == 2) begin
                check("sink_fc3", 64'(s_fc), 64'd3);
                check("sink_dc3", 64'(s_dc), 64'd3);
            end
        end
        check("sink_fc_sat", 64'(s_fc), 64'd15);
        check("sink_dc_sat", 64'(s_dc), 64'd15);
        check("sink_occ", 64'(s_occ), 64'd0);
        check("sink_dout", 64'(s_dout), 64'd0);
        check("blk_fc", 64'(b_fc), 64'd0);
        check("blk_dc", 64'(b_dc), 64'd0);
        check("blk_dout", 64'(b_dout), 64'd0);
        s_vin = 1'b0;
        b_vin = 1'b0;

        // PASS streaming: one flit per cycle accepted with rin high.
        p_rin = 1'b1;
        p_vin = 1'b1;
        p_din = 32'h11;
        tick();
        check("stream_acc0", 64'(p_acc), 64'd1);
        p_din = 32'h22;
        tick();
        check("stream_acc1", 64'(p_acc), 64'd1);
        p_din = 32'h33;
        tick();
        check("stream_acc2", 64'(p_acc), 64'd1);
        p_vin = 1'b0;
        tick();
        tick();
        check("stream_fc", 64'(p_fc), 64'd3);

        // Backpressure, then a second fill/drain to wrap the pointers.
        fill_drain(32'hA0);
        fill_drain(32'hB0);

        // Reset with flits queued flushes them; the next flit is the first delivered.
        p_rin = 1'b0;
        p_vin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p_din = 32'hC0 + i;
            tick();
        end
        p_vin = 1'b0;
        p_rst = 1'b1;
        tick();
        p_rst = 1'b0;
        check("rst_occ", 64'(p_occ), 64'd0);
        check("rst_vout", 64'(p_vout), 64'd0);
        check("rst_rout", 64'(p_rout), 64'd1);
        check("rst_fc", 64'(p_fc), 64'd0);
        p_vin = 1'b1;
        p_din = 32'h55;
        tick();
        p_vin = 1'b0;
        check("post_rst_dout", 64'(p_dout), 64'h55);
        p_rin = 1'b1;
        tick();
        tick();

        // Random traffic honouring the hold-until-accepted rule, with one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            tick();
            p_rst = (c == 1500);
            if (!p_vin || p_acc) begin
                p_vin = ($urandom_range(0, 99) < 70);
                p_din = $urandom;
            end
            p_rin = ($urandom_range(0, 99) < ((c < 1000) ? 40 : 90));
        end
        p_rst = 1'b0;
        p_vin = 1'b0;
        p_rin = 1'b1;
        for (int i = 0; i < PD + 3; i++) tick();
        check("final_drained", 64'(exp_q.size()), 64'd0);
        check("final_occ", 64'(p_occ), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
